base_unpacker: RTL



---
 rtl/base_pkg.sv | 30 +++
 rtl/base_unpack_fifo.sv | 76 +++++++
 rtl/base_unpacker.sv | 105 ++++++++++
 3 files changed

// File: rtl/base_pkg.sv
// -----------------------------------------------------------------------------
// base_pkg
// Shared helpers for the base-item width converters.
//   log2   : ceiling log2, with log2(1) = 0 (same definition as the base RAM)
//   maxInt : larger of two integers
//   minInt : smaller of two integers
// The packed buffer entry {data, count, last} depends on the converter's
// WIDTHI/CNTW parameters, so it is declared next to its storage in
// base_unpack_fifo.
// -----------------------------------------------------------------------------
package base_pkg;

   function automatic int log2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r++;
      end
      return r;
   endfunction

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int minInt(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/base_unpack_fifo.sv
// -----------------------------------------------------------------------------
// base_unpack_fifo
// Two-entry synchronous FIFO of {data, count, last} words.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   push, pushData/Count/Last  write request and entry (ignored when full)
//   pop                        remove head entry (ignored when empty)
//   full, empty                registered occupancy flags
//   headData/Count/Last        oldest entry, valid while !empty
// Only pointers and occupancy are reset; entry storage is qualified by
// occupancy and never observed while empty.
// -----------------------------------------------------------------------------
module base_unpack_fifo #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] pushData,
   input  logic [CNT_W-1:0]  pushCount,
   input  logic              pushLast,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] headData,
   output logic [CNT_W-1:0]  headCount,
   output logic              headLast
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [CNT_W-1:0]  count;
      logic              last;
   } entry_t;

   entry_t     mem [2];
   logic       wrPtr;
   logic       rdPtr;
   logic [1:0] occ;
   logic       doPush;
   logic       doPop;

   assign full   = (occ == 2'd2);
   assign empty  = (occ == 2'd0);
   assign doPush = push && !full;
   assign doPop  = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= 1'b0;
         rdPtr <= 1'b0;
         occ   <= 2'd0;
      end else begin
         if (doPush) wrPtr <= ~wrPtr;
         if (doPop)  rdPtr <= ~rdPtr;
         // Push and pop together leave occupancy unchanged.
         case ({doPush, doPop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= '{data: pushData, count: pushCount, last: pushLast};
      end
   end

   assign headData  = mem[rdPtr].data;
   assign headCount = mem[rdPtr].count;
   assign headLast  = mem[rdPtr].last;

endmodule

// File: rtl/base_unpacker.sv
// -----------------------------------------------------------------------------
// base_unpacker
// Width-down converter: accepts WIDTHI-bit packed words and emits WIDTHO-bit
// items LSB-first, one per cycle, each tagged with its index in the packet.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   in_valid/ready  word handshake (in_ready from registered occupancy only)
//   in_data         packed items, item k at bits [(k+1)*WIDTHO-1 : k*WIDTHO]
//   in_count        number of valid items in the word minus 1
//   in_last         word closes a packet
//   out_valid/ready item handshake
//   out_data        current item (0 while nothing is buffered)
//   out_last        final item of the packet
//   out_index       0-based item position within the packet, modulo 2^LENW
// All out_* are driven from the buffer, sub counter and index counter, so no
// input port reaches an output combinationally.
// -----------------------------------------------------------------------------
module base_unpacker
   import base_pkg::*;
#(
   parameter int  WIDTHI = 32,
   parameter int  WIDTHO = 8,
   parameter int  LENW   = 16,
   localparam int RATIO  = WIDTHI / WIDTHO,
   localparam int CNTW   = maxInt(1, log2(RATIO))
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTHI-1:0] in_data,
   input  logic [CNTW-1:0]   in_count,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTHO-1:0] out_data,
   output logic              out_last,
   output logic [LENW-1:0]   out_index
);

   logic              full;
   logic              empty;
   logic [WIDTHI-1:0] headData;
   logic [CNTW-1:0]   headCount;
   logic              headLast;
   logic [CNTW-1:0]   sub;
   logic [LENW-1:0]   idx;
   logic [WIDTHO-1:0] item;
   logic              lastOfWord;
   logic              fire;
   logic              popHead;

   base_unpack_fifo #(
      .DATA_W (WIDTHI),
      .CNT_W  (CNTW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid),
      .pushData  (in_data),
      .pushCount (in_count),
      .pushLast  (in_last),
      .pop       (popHead),
      .full      (full),
      .empty     (empty),
      .headData  (headData),
      .headCount (headCount),
      .headLast  (headLast)
   );

   assign in_ready   = !full;
   assign out_valid  = !empty;
   assign lastOfWord = (sub == headCount);
   assign fire       = out_valid && out_ready;
   // Popping on the word's last item lets the next word present item 0 in
   // the very next cycle, so consecutive words stream without bubbles.
   assign popHead    = fire && lastOfWord;

   // Output mux: item 'sub' of the head word.
   always_comb begin
      item = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (CNTW'(k) == sub) begin
            item = headData[k*WIDTHO +: WIDTHO];
         end
      end
   end

   // Masking with out_valid keeps the outputs at 0 while the buffer is empty,
   // which includes the cycles right after reset.
   assign out_data  = out_valid ? item : '0;
   assign out_last  = out_valid && headLast && lastOfWord;
   assign out_index = idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sub <= '0;
         idx <= '0;
      end else if (fire) begin
         sub <= lastOfWord ? '0 : sub + CNTW'(1);
         idx <= out_last ? '0 : idx + LENW'(1);
      end
   end

endmodule
